// File: rtl/pixel_serial_emitter_if.sv
// Frame-capture and serial-bit handshake bundle for pixel_serial_emitter.
// master = emitter side, slave = frame source / bit sink side.
interface pixel_serial_emitter_if #(
    parameter int unsigned PIXEL_COUNT = 784,
    parameter int unsigned DATA_WIDTH  = 16
);
    logic                              frame_valid;
    logic                              frame_ready;
    logic [DATA_WIDTH*PIXEL_COUNT-1:0] frame_flat;
    logic                              pixel_bit;
    logic                              pixel_bit_valid;
    logic                              pixel_bit_ready;
    logic                              pixel_last;
    logic                              busy;
    logic                              frame_done;

    modport master (
        input  frame_valid, frame_flat, pixel_bit_ready,
        output frame_ready, pixel_bit, pixel_bit_valid, pixel_last, busy, frame_done
    );

    modport slave (
        output frame_valid, frame_flat, pixel_bit_ready,
        input  frame_ready, pixel_bit, pixel_bit_valid, pixel_last, busy, frame_done
    );
endinterface

// File: rtl/pixel_serial_emitter.sv
// Thresholds a Q8.8 frame to one bit per pixel at capture and streams the bits out serially.
// Optional trailing XOR parity bit when PIXEL_EMITTER_PARITY_EN is defined.
module pixel_serial_emitter #(
    parameter int unsigned                  PIXEL_COUNT = 784,
    parameter int unsigned                  DATA_WIDTH  = 16,
    parameter logic signed [DATA_WIDTH-1:0] THRESHOLD   = 16'sh0080
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pixel_serial_emitter_if.master bus
);

`ifdef PIXEL_EMITTER_PARITY_EN
    localparam int unsigned BIT_COUNT = PIXEL_COUNT + 1;
`else
    localparam int unsigned BIT_COUNT = PIXEL_COUNT;
`endif
    localparam int unsigned       IDX_W    = $clog2(PIXEL_COUNT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BIT_COUNT - 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [IDX_W-1:0]       index_q, index_d;
    logic [PIXEL_COUNT-1:0] shadow_q, shadow_d;
    logic                   bit_q, bit_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   armed_q;

    logic [PIXEL_COUNT-1:0] thresh;
    logic [IDX_W-1:0]       index_nxt;
    logic                   bit_nxt;
    logic                   frame_ready_c;

    // armed_q keeps frame_ready low while in reset and until the first edge after release
    assign frame_ready_c   = armed_q && (state_q == IDLE);
    assign bus.frame_ready = frame_ready_c;

    assign bus.pixel_bit       = bit_q;
    assign bus.pixel_bit_valid = valid_q;
    assign bus.pixel_last      = last_q;
    assign bus.busy            = busy_q;
    assign bus.frame_done      = done_q;

    // Signed per-pixel threshold of the whole incoming frame
    always_comb begin
        thresh = '0;
        for (int unsigned i = 0; i < PIXEL_COUNT; i++) begin
            thresh[i] = $signed(bus.frame_flat[i*DATA_WIDTH +: DATA_WIDTH]) >= THRESHOLD;
        end
    end

    // Bit presented after the current one is accepted
    always_comb begin
        index_nxt = index_q + IDX_W'(1);
`ifdef PIXEL_EMITTER_PARITY_EN
        bit_nxt   = (index_nxt == IDX_W'(PIXEL_COUNT)) ? ^shadow_q : shadow_q[index_nxt];
`else
        bit_nxt   = shadow_q[index_nxt];
`endif
    end

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        shadow_d = shadow_q;
        bit_d    = bit_q;
        valid_d  = valid_q;
        last_d   = last_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.frame_valid && frame_ready_c) begin
                    state_d  = STREAM;
                    shadow_d = thresh;
                    index_d  = '0;
                    bit_d    = thresh[0];
                    valid_d  = 1'b1;
                    last_d   = (LAST_IDX == '0);
                    busy_d   = 1'b1;
                end
            end
            STREAM: begin
                if (valid_q && bus.pixel_bit_ready) begin
                    if (index_q == LAST_IDX) begin
                        state_d = IDLE;
                        bit_d   = 1'b0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        index_d = index_nxt;
                        bit_d   = bit_nxt;
                        last_d  = (index_nxt == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            index_q  <= '0;
            shadow_q <= '0;
            bit_q    <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            shadow_q <= shadow_d;
            bit_q    <= bit_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            armed_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pixel_serial_emitter.sv
// Self-checking bench for pixel_serial_emitter: threshold table vectors plus a bit scoreboard.
module tb_pixel_serial_emitter;
    localparam int unsigned PC = 784;
    localparam int unsigned DW = 16;
`ifdef PIXEL_EMITTER_PARITY_EN
    localparam int unsigned NB = PC + 1;
`else
    localparam int unsigned NB = PC;
`endif
    localparam int unsigned NT = 8;

    typedef struct { logic [DW-1:0] px; logic exp_bit; } vec_t;
    typedef struct packed { logic b; logic last; } sb_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pixel_serial_emitter_if #(.PIXEL_COUNT(PC), .DATA_WIDTH(DW)) bus ();

    pixel_serial_emitter #(.PIXEL_COUNT(PC), .DATA_WIDTH(DW), .THRESHOLD(16'sh0080)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          cap_cyc = 0;
    int          prev_cap_cyc = 0;
    int          n_cap = 0;
    int          done_cyc = 0;
    int          n_done = 0;
    bit          armed = 1'b0;
    bit          rand_ready = 1'b0;
    bit          exp_done = 1'b0;
    bit          prev_stall = 1'b0;
    logic        prev_bit = 1'b0;
    logic        prev_last = 1'b0;
    sb_t         sb [$];
    logic [DW-1:0] px [PC];
    logic        eb [PC];
    vec_t        tbl [NT];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic thr(input logic [DW-1:0] p);
        return $signed(p) >= $signed(16'h0080);
    endfunction

    task automatic load_frame();
        for (int i = 0; i < PC; i++) bus.frame_flat[i*DW +: DW] = px[i];
    endtask

    task automatic scramble_flat();
        for (int i = 0; i < PC; i++) bus.frame_flat[i*DW +: DW] = 16'($urandom);
    endtask

    task automatic set_model_bits();
        for (int i = 0; i < PC; i++) eb[i] = thr(px[i]);
    endtask

    // One clock: pre-edge handshake/capture bookkeeping, post-edge checks at negedge
    task automatic step();
        sb_t e;
        logic par;
        bit hs, cap;
        cap = bus.frame_valid && bus.frame_ready && rst_n;
        hs  = bus.pixel_bit_valid && bus.pixel_bit_ready;
        exp_done = 1'b0;
        if (hs) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("bit_last", 32'({bus.pixel_bit, bus.pixel_last}), 32'({e.b, e.last}));
                exp_done = e.last;
            end
        end
        if (cap) begin
            par = 1'b0;
            for (int i = 0; i < PC; i++) begin
                sb.push_back('{b: eb[i], last: (i == NB - 1)});
                par ^= eb[i];
            end
`ifdef PIXEL_EMITTER_PARITY_EN
            sb.push_back('{b: par, last: 1'b1});
`endif
            prev_cap_cyc = cap_cyc;
            cap_cyc = cyc;
            n_cap++;
        end
        prev_stall = bus.pixel_bit_valid && !bus.pixel_bit_ready;
        prev_bit   = bus.pixel_bit;
        prev_last  = bus.pixel_last;
        armed      = armed | rst_n;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (prev_stall)
            chk("stall_hold", 32'({bus.pixel_bit_valid, bus.pixel_bit, bus.pixel_last}),
                32'({1'b1, prev_bit, prev_last}));
        chk("frame_done", 32'(bus.frame_done), 32'(exp_done));
        if (bus.frame_done) begin
            n_done++;
            done_cyc = cyc;
        end
        chk("status", 32'({bus.busy, bus.pixel_bit_valid, bus.frame_ready}),
            32'({sb.size() != 0, sb.size() != 0, armed && sb.size() == 0}));
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            bus.pixel_bit_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            k++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
        bus.pixel_bit_ready = 1'b1;
    endtask

    // Offer the current px/eb frame for one cycle, then corrupt frame_flat
    task automatic send_frame(input int budget);
        load_frame();
        bus.frame_valid = 1'b1;
        step();
        bus.frame_valid = 1'b0;
        scramble_flat();
        drain(budget);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        tbl[0] = '{px: 16'h0080, exp_bit: 1'b1};
        tbl[1] = '{px: 16'h007F, exp_bit: 1'b0};
        tbl[2] = '{px: 16'hFF00, exp_bit: 1'b0};
        tbl[3] = '{px: 16'h7FFF, exp_bit: 1'b1};
        tbl[4] = '{px: 16'h0100, exp_bit: 1'b1};
        tbl[5] = '{px: 16'h0000, exp_bit: 1'b0};
        tbl[6] = '{px: 16'h8000, exp_bit: 1'b0};
        tbl[7] = '{px: 16'h0081, exp_bit: 1'b1};

        bus.frame_valid     = 1'b0;
        bus.pixel_bit_ready = 1'b1;
        bus.frame_flat      = '0;

        // Reset values while rst_n is held low
        @(negedge clk);
        chk("rst_outputs", 32'({bus.frame_ready, bus.pixel_bit, bus.pixel_bit_valid,
            bus.pixel_last, bus.busy, bus.frame_done}), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", 32'(bus.frame_ready), 32'd1);

        // All pixels 1.0: all ones, single frame_done at cycle NB+1 after capture
        for (int i = 0; i < PC; i++) begin
            px[i] = 16'h0100;
            eb[i] = 1'b1;
        end
        n_done = 0;
        send_frame(NB + 20);
        step();
        chk("done_count", 32'(n_done), 32'd1);
        chk("done_latency", 32'(done_cyc - cap_cyc), 32'(NB + 1));

        // Threshold boundary table, ready high then random ready
        for (int r = 0; r < 2; r++) begin
            rand_ready = (r == 1);
            for (int i = 0; i < PC; i++) begin
                px[i] = tbl[i % NT].px;
                eb[i] = tbl[i % NT].exp_bit;
            end
            send_frame(NB * 8 + 100);
        end
        rand_ready = 1'b0;

        // Back-to-back: random frame then single-one frame, frame_valid held high
        for (int i = 0; i < PC; i++) px[i] = 16'($urandom);
        set_model_bits();
        load_frame();
        bus.frame_valid = 1'b1;
        d0 = n_cap;
        step();
        for (int i = 0; i < PC; i++) px[i] = (i == 5) ? 16'h0100 : 16'h0000;
        set_model_bits();
        load_frame();
        for (int k = 0; k < NB + 20 && n_cap < d0 + 2; k++) step();
        bus.frame_valid = 1'b0;
        chk("b2b_captures", 32'(n_cap - d0), 32'd2);
        chk("b2b_gap", 32'(cap_cyc - prev_cap_cyc), 32'(NB + 1));
        drain(NB + 20);

        // Reset mid-frame at bit 300, then a fresh frame starts at pixel 0
        for (int i = 0; i < PC; i++) px[i] = 16'($urandom);
        set_model_bits();
        load_frame();
        bus.frame_valid = 1'b1;
        step();
        bus.frame_valid = 1'b0;
        for (int k = 0; k < NB && sb.size() > NB - 300; k++) step();
        chk("pre_reset_pos", 32'(sb.size()), 32'(NB - 300));
        rst_n = 1'b0;
        #1;
        chk("async_reset", 32'({bus.frame_ready, bus.pixel_bit, bus.pixel_bit_valid,
            bus.pixel_last, bus.busy, bus.frame_done}), 32'd0);
        sb.delete();
        armed = 1'b0;
        prev_stall = 1'b0;
        @(negedge clk);
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < PC; i++) begin
            px[i] = tbl[(i + 3) % NT].px;
            eb[i] = tbl[(i + 3) % NT].exp_bit;
        end
        send_frame(NB + 20);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
